// File: rtl/digit_pkg.sv
// Shared digit encoding for the dual-rail style digit latch bank.
// A digit is two bits: null, logic 0, logic 1, or the illegal code.
package digit_pkg;
  localparam int DIGIT_W = 2;
  typedef logic [DIGIT_W-1:0] digit_t;

  localparam digit_t DIGIT_NULL    = 2'b00;
  localparam digit_t DIGIT_ZERO    = 2'b01;
  localparam digit_t DIGIT_ONE     = 2'b10;
  localparam digit_t DIGIT_ILLEGAL = 2'b11;

  // Illegal digits are never stored; they collapse to null.
  function automatic digit_t sanitize(digit_t d);
    return (d == DIGIT_ILLEGAL) ? DIGIT_NULL : d;
  endfunction
endpackage

// File: rtl/digit_latch_bank_if.sv
// Request/response bundle between the strobe front end and the word store.
// Strobes on this bundle are already single-cycle pulses.
interface digit_latch_bank_if
  import digit_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DEPTH  = 8
);
  localparam int AW = $clog2(DEPTH);

  logic                     wr_en;
  logic [AW-1:0]            wr_addr;
  digit_t [DIGITS-1:0]      wr_data;
  logic                     clr;
  logic                     rd_en;
  logic [AW-1:0]            rd_addr;
  digit_t [DIGITS-1:0]      rd_data;
  logic                     rd_valid;

  modport master (
    output wr_en, wr_addr, wr_data, clr, rd_en, rd_addr,
    input  rd_data, rd_valid
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, clr, rd_en, rd_addr,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/digit_latch_bank_store.sv
// Word array with per-word valid bits and a registered read port.
// Reads sample the pre-edge array, so same-edge write/clear never leaks into a read.
module digit_latch_bank_store
  import digit_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DEPTH  = 8
) (
  input  logic                Clock,
  input  logic                nReset,
  digit_latch_bank_if.slave   bus
);
  digit_t [DIGITS-1:0] mem [DEPTH];
  logic   [DEPTH-1:0]  valid;
  digit_t [DIGITS-1:0] clean;

  for (genvar g = 0; g < DIGITS; g++) begin : g_lane
    assign clean[g] = sanitize(bus.wr_data[g]);
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      valid        <= '0;
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
    end else begin
      if (bus.rd_en) begin
        // Invalid words read back as all-null regardless of stale contents.
        bus.rd_data  <= valid[bus.rd_addr] ? mem[bus.rd_addr] : '0;
        bus.rd_valid <= valid[bus.rd_addr];
      end
      if (bus.clr) valid <= '0;
      if (bus.wr_en) begin
        mem[bus.wr_addr]   <= clean;
        valid[bus.wr_addr] <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/edge_pulse.sv
// Registered rising-edge detector: one-cycle pulse when strobe goes 0->1.
// A strobe already high out of reset counts as an edge on the first clock.
module edge_pulse (
  input  logic Clock,
  input  logic nReset,
  input  logic strobe,
  output logic pulse
);
  logic strobe_q;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) strobe_q <= 1'b0;
    else         strobe_q <= strobe;
  end

  assign pulse = strobe & ~strobe_q;
endmodule

// File: rtl/digit_latch_bank.sv
// Edge-strobed bank of DEPTH words of DIGITS two-bit digits with valid bits,
// synchronous clear-all and a sticky illegal-digit flag.
module digit_latch_bank
  import digit_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                      Clock,
  input  logic                      nReset,
  input  logic                      WriteEdge,
  input  logic [AW-1:0]             WriteAddr,
  input  logic [DIGIT_W*DIGITS-1:0] inputData,
  input  logic                      ReadEdge,
  input  logic [AW-1:0]             ReadAddr,
  input  logic                      ClearAll,
  output logic [DIGIT_W*DIGITS-1:0] outputData,
  output logic                      outputValid,
  output logic                      DigitError
);
  logic wr_pulse, rd_pulse, any_illegal;

  edge_pulse u_wr_edge (.Clock(Clock), .nReset(nReset), .strobe(WriteEdge), .pulse(wr_pulse));
  edge_pulse u_rd_edge (.Clock(Clock), .nReset(nReset), .strobe(ReadEdge),  .pulse(rd_pulse));

  digit_latch_bank_if #(.DIGITS(DIGITS), .DEPTH(DEPTH)) bus ();

  assign bus.wr_en   = wr_pulse;
  assign bus.wr_addr = WriteAddr;
  assign bus.wr_data = inputData;
  assign bus.clr     = ClearAll;
  assign bus.rd_en   = rd_pulse;
  assign bus.rd_addr = ReadAddr;
  assign outputData  = bus.rd_data;
  assign outputValid = bus.rd_valid;

  digit_latch_bank_store #(.DIGITS(DIGITS), .DEPTH(DEPTH)) u_store (
    .Clock (Clock),
    .nReset(nReset),
    .bus   (bus)
  );

  always_comb begin
    any_illegal = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (inputData[DIGIT_W*i +: DIGIT_W] == DIGIT_ILLEGAL) any_illegal = 1'b1;
  end

  // Only digits that are actually written can raise the flag.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset)                       DigitError <= 1'b0;
    else if (wr_pulse && any_illegal)  DigitError <= 1'b1;
  end
endmodule

// File: tb/tb_digit_latch_bank.sv
// Directed bench for digit_latch_bank: inputs change on the falling edge,
// outputs are sampled on the falling edge after the capturing rising edge.
module tb_digit_latch_bank;
  logic Clock = 1'b0;
  logic nReset;
  logic derr;
  int   passed = 0;
  int   total  = 0;

  digit_latch_bank_if #(.DIGITS(4), .DEPTH(8)) bus ();

  digit_latch_bank #(.DIGITS(4), .DEPTH(8)) dut (
    .Clock      (Clock),
    .nReset     (nReset),
    .WriteEdge  (bus.wr_en),
    .WriteAddr  (bus.wr_addr),
    .inputData  (bus.wr_data),
    .ReadEdge   (bus.rd_en),
    .ReadAddr   (bus.rd_addr),
    .ClearAll   (bus.clr),
    .outputData (bus.rd_data),
    .outputValid(bus.rd_valid),
    .DigitError (derr)
  );

  always #5 Clock = ~Clock;

  task automatic do_write(input logic [2:0] a, input logic [7:0] d);
    bus.wr_addr = a; bus.wr_data = d; bus.wr_en = 1'b1;
    @(negedge Clock);
    bus.wr_en = 1'b0;
    @(negedge Clock);
  endtask

  task automatic do_read(input logic [2:0] a);
    bus.rd_addr = a; bus.rd_en = 1'b1;
    @(negedge Clock);
    bus.rd_en = 1'b0;
    @(negedge Clock);
  endtask

  task automatic test_reset;
    nReset = 1'b0;
    bus.wr_en = 0; bus.rd_en = 0; bus.clr = 0;
    bus.wr_addr = '0; bus.rd_addr = '0; bus.wr_data = '0;
    repeat (2) @(negedge Clock);
    total++; if (bus.rd_data !== 8'h00) $display("FAIL reset_data got %h want 00", bus.rd_data); else passed++;
    total++; if (bus.rd_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.rd_valid); else passed++;
    total++; if (derr !== 1'b0) $display("FAIL reset_err got %b want 0", derr); else passed++;
    nReset = 1'b1;
    @(negedge Clock);
    do_read(3'd3);
    total++; if (bus.rd_data !== 8'h00) $display("FAIL unwritten_data got %h want 00", bus.rd_data); else passed++;
    total++; if (bus.rd_valid !== 1'b0) $display("FAIL unwritten_valid got %b want 0", bus.rd_valid); else passed++;
  endtask

  task automatic test_write_read;
    do_write(3'd5, 8'b10_01_10_01);
    bus.rd_addr = 3'd5; bus.rd_en = 1'b1;
    @(negedge Clock);
    total++; if (bus.rd_data !== 8'h99) $display("FAIL wr_rd_data got %h want 99", bus.rd_data); else passed++;
    total++; if (bus.rd_valid !== 1'b1) $display("FAIL wr_rd_valid got %b want 1", bus.rd_valid); else passed++;
    bus.rd_en = 1'b0;
    repeat (3) @(negedge Clock);
    total++; if (bus.rd_data !== 8'h99) $display("FAIL hold_data got %h want 99", bus.rd_data); else passed++;
  endtask

  task automatic test_clear_alone;
    bus.clr = 1'b1;
    @(negedge Clock);
    bus.clr = 1'b0;
    @(negedge Clock);
    total++; if (bus.rd_data !== 8'h99 || bus.rd_valid !== 1'b1)
      $display("FAIL clear_alone got %h/%b want 99/1", bus.rd_data, bus.rd_valid); else passed++;
    do_read(3'd5);
    total++; if (bus.rd_data !== 8'h00 || bus.rd_valid !== 1'b0)
      $display("FAIL cleared_word got %h/%b want 00/0", bus.rd_data, bus.rd_valid); else passed++;
  endtask

  task automatic test_held_strobe;
    bus.wr_addr = 3'd4; bus.wr_en = 1'b1;
    bus.wr_data = 8'h55; @(negedge Clock);
    bus.wr_data = 8'hAA; @(negedge Clock);
    bus.wr_data = 8'h66; @(negedge Clock);
    bus.wr_data = 8'h99; @(negedge Clock);
    bus.wr_en = 1'b0;    @(negedge Clock);
    do_read(3'd4);
    total++; if (bus.rd_data !== 8'h55) $display("FAIL held_strobe got %h want 55", bus.rd_data); else passed++;
  endtask

  task automatic test_back_to_back;
    do_write(3'd2, 8'h55);
    bus.wr_addr = 3'd2; bus.wr_data = 8'hAA; bus.wr_en = 1'b1;
    bus.rd_addr = 3'd2; bus.rd_en = 1'b1;
    @(negedge Clock);
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    @(negedge Clock);
    total++; if (bus.rd_data !== 8'h55) $display("FAIL rbw_old got %h want 55", bus.rd_data); else passed++;
    do_read(3'd2);
    total++; if (bus.rd_data !== 8'hAA) $display("FAIL rbw_new got %h want aa", bus.rd_data); else passed++;
  endtask

  task automatic test_illegal;
    total++; if (derr !== 1'b0) $display("FAIL err_before got %b want 0", derr); else passed++;
    do_write(3'd7, 8'b11_10_01_10);
    total++; if (derr !== 1'b1) $display("FAIL err_set got %b want 1", derr); else passed++;
    do_read(3'd7);
    total++; if (bus.rd_data !== 8'b00_10_01_10) $display("FAIL illegal_store got %h want 26", bus.rd_data); else passed++;
    do_write(3'd7, 8'h55);
    do_read(3'd7);
    total++; if (derr !== 1'b1) $display("FAIL err_sticky got %b want 1", derr); else passed++;
    total++; if (bus.rd_data !== 8'h55) $display("FAIL legal_after got %h want 55", bus.rd_data); else passed++;
  endtask

  task automatic test_clear_with_write;
    do_write(3'd0, 8'h99);
    bus.clr = 1'b1;
    bus.wr_addr = 3'd1; bus.wr_data = 8'h66; bus.wr_en = 1'b1;
    bus.rd_addr = 3'd0; bus.rd_en = 1'b1;
    @(negedge Clock);
    bus.clr = 1'b0; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    @(negedge Clock);
    total++; if (bus.rd_data !== 8'h99 || bus.rd_valid !== 1'b1)
      $display("FAIL clr_preread got %h/%b want 99/1", bus.rd_data, bus.rd_valid); else passed++;
    do_read(3'd1);
    total++; if (bus.rd_data !== 8'h66 || bus.rd_valid !== 1'b1)
      $display("FAIL clr_write_wins got %h/%b want 66/1", bus.rd_data, bus.rd_valid); else passed++;
    do_read(3'd0);
    total++; if (bus.rd_data !== 8'h00 || bus.rd_valid !== 1'b0)
      $display("FAIL clr_addr0 got %h/%b want 00/0", bus.rd_data, bus.rd_valid); else passed++;
    do_read(3'd4);
    total++; if (bus.rd_data !== 8'h00 || bus.rd_valid !== 1'b0)
      $display("FAIL clr_addr4 got %h/%b want 00/0", bus.rd_data, bus.rd_valid); else passed++;
  endtask

  task automatic test_mid_reset;
    do_read(3'd1);
    bus.wr_addr = 3'd3; bus.wr_data = 8'h99; bus.wr_en = 1'b1;
    bus.rd_addr = 3'd1; bus.rd_en = 1'b1;
    #2 nReset = 1'b0;
    #1;
    total++; if (bus.rd_data !== 8'h00 || bus.rd_valid !== 1'b0 || derr !== 1'b0)
      $display("FAIL mid_reset got %h/%b/%b want 00/0/0", bus.rd_data, bus.rd_valid, derr); else passed++;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    @(negedge Clock);
    nReset = 1'b1;
    @(negedge Clock);
    do_read(3'd3);
    total++; if (bus.rd_data !== 8'h00 || bus.rd_valid !== 1'b0)
      $display("FAIL abandoned_write got %h/%b want 00/0", bus.rd_data, bus.rd_valid); else passed++;
  endtask

  task automatic test_strobe_at_reset;
    nReset = 1'b0;
    bus.wr_addr = 3'd6; bus.wr_data = 8'h66; bus.wr_en = 1'b1;
    @(negedge Clock);
    nReset = 1'b1;
    @(negedge Clock);
    bus.wr_en = 1'b0;
    @(negedge Clock);
    do_read(3'd6);
    total++; if (bus.rd_data !== 8'h66 || bus.rd_valid !== 1'b1)
      $display("FAIL strobe_at_reset got %h/%b want 66/1", bus.rd_data, bus.rd_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_clear_alone();
    test_held_strobe();
    test_back_to_back();
    test_illegal();
    test_clear_with_write();
    test_mid_reset();
    test_strobe_at_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
